// File: rtl/ram_burst_reader.sv
// Burst reader for the `ram` block: issues credit-limited reads and streams the
// returned words downstream through a small FIFO with valid/ready backpressure.

package funcPckg;
  localparam int cRamDepth = 32;
  localparam int cRamWidth = 8;
  localparam int AW        = $clog2(cRamDepth);

  typedef struct packed {
    logic [cRamWidth-1:0] data;
    logic [AW-1:0]        addr;
    logic                 en;
    logic                 wEn;
  } tRamInData;

  typedef struct packed {
    logic [cRamWidth-1:0] data;
    logic [AW-1:0]        addr;
    logic                 dv;
  } tRamOutData;
endpackage

module ram_burst_reader
  import funcPckg::*;
#(
  parameter int cRdLatency = 3,
  parameter int cFifoDepth = 8
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iStart,
  input  logic [AW-1:0]        iBaseAddr,
  input  logic [AW:0]          iLen,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oErr,
  output tRamInData            oRam,
  input  tRamOutData           iRam,
  output logic [cRamWidth-1:0] oData,
  output logic [AW-1:0]        oAddr,
  output logic                 oValid,
  output logic                 oLast,
  input  logic                 iReady
);

  localparam int cPtrW = $clog2(cFifoDepth);
  localparam int cCntW = cPtrW + 1;
  localparam int cOutW = $clog2(cRdLatency + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e               r_state, w_next_state;
  logic [AW-1:0]        r_cur_addr, r_exp_addr;
  logic [AW:0]          r_len, r_issued, r_popped;
  logic [cOutW-1:0]     r_outstanding;
  logic [cCntW-1:0]     r_count;
  logic [cPtrW-1:0]     r_wptr, r_rptr;
  logic                 r_err, r_done;
  logic [cRamWidth-1:0] r_fifo_data [cFifoDepth];
  logic [AW-1:0]        r_fifo_addr [cFifoDepth];

  logic                 w_start, w_start_zero, w_has_credit, w_issue;
  logic                 w_push, w_pop, w_last_beat, w_finish;
  logic [cCntW:0]       w_used;

  function automatic logic [AW-1:0] f_next_addr(input logic [AW-1:0] a);
    return (a == AW'(cRamDepth - 1)) ? '0 : a + AW'(1);
  endfunction

  assign w_start      = (r_state == IDLE) && iStart && (iLen != '0);
  assign w_start_zero = (r_state == IDLE) && iStart && (iLen == '0);
  // A read may only be issued if its response is guaranteed a FIFO slot.
  assign w_used       = (cCntW+1)'(r_count) + (cCntW+1)'(r_outstanding);
  assign w_has_credit = w_used < (cCntW+1)'(cFifoDepth);
  assign w_issue      = (r_state == ISSUE) && w_has_credit;
  assign w_push       = iRam.dv && (r_outstanding != '0);
  assign w_pop        = oValid && iReady;
  assign w_last_beat  = (r_popped == r_len - (AW+1)'(1));
  assign w_finish     = (r_state == DRAIN) && w_pop && w_last_beat;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    oRam         = '0;
    if (w_issue) begin
      oRam.en   = 1'b1;
      oRam.addr = r_cur_addr;
    end
    case (r_state)
      IDLE:    if (w_start) w_next_state = ISSUE;
      ISSUE:   if (w_issue && (r_issued == r_len - (AW+1)'(1))) w_next_state = DRAIN;
      DRAIN:   if (w_finish) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_cur_addr    <= '0;
      r_exp_addr    <= '0;
      r_len         <= '0;
      r_issued      <= '0;
      r_popped      <= '0;
      r_outstanding <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_err         <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= w_start_zero || w_finish;
      if (w_start) begin
        r_cur_addr <= iBaseAddr;
        r_exp_addr <= iBaseAddr;
        r_len      <= iLen;
        r_issued   <= '0;
        r_popped   <= '0;
        r_err      <= 1'b0;
      end else begin
        if (w_issue) begin
          r_cur_addr <= f_next_addr(r_cur_addr);
          r_issued   <= r_issued + (AW+1)'(1);
        end
        if (w_push) begin
          r_exp_addr <= f_next_addr(r_exp_addr);
          if (iRam.addr != r_exp_addr) r_err <= 1'b1;
        end
        if (w_pop) r_popped <= r_popped + (AW+1)'(1);
      end

      case ({w_issue, w_push})
        2'b10:   r_outstanding <= r_outstanding + cOutW'(1);
        2'b01:   r_outstanding <= r_outstanding - cOutW'(1);
        default: r_outstanding <= r_outstanding;
      endcase

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + cCntW'(1);
        2'b01:   r_count <= r_count - cCntW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push) r_wptr <= r_wptr + cPtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + cPtrW'(1);
    end
  end

  // NOTE: FIFO storage has no reset; r_count alone decides which entries are live.
  always_ff @(posedge iClk) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= iRam.data;
      r_fifo_addr[r_wptr] <= iRam.addr;
    end
  end

  assign oValid = (r_count != '0);
  assign oData  = r_fifo_data[r_rptr];
  assign oAddr  = r_fifo_addr[r_rptr];
  assign oLast  = oValid && w_last_beat;
  assign oBusy  = (r_state != IDLE);
  assign oDone  = r_done;
  assign oErr   = r_err;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: a latency-accurate `ram` model feeds the DUT and a
// scoreboard queue of expected beats is drained by an independent stream monitor.

module tb_ram_burst_reader;
  import funcPckg::*;

  localparam int cLat   = 3;
  localparam int cDepth = 8;

  logic                 iClk = 1'b0;
  logic                 iRst = 1'b1;
  logic                 iStart = 1'b0;
  logic [AW-1:0]        iBaseAddr = '0;
  logic [AW:0]          iLen = '0;
  logic                 iReady = 1'b1;
  logic                 oBusy, oDone, oErr, oValid, oLast;
  logic [cRamWidth-1:0] oData;
  logic [AW-1:0]        oAddr;
  tRamInData            oRam;
  tRamOutData           iRam;

  ram_burst_reader #(.cRdLatency(cLat), .cFifoDepth(cDepth)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iBaseAddr(iBaseAddr), .iLen(iLen),
    .oBusy(oBusy), .oDone(oDone), .oErr(oErr), .oRam(oRam), .iRam(iRam),
    .oData(oData), .oAddr(oAddr), .oValid(oValid), .oLast(oLast), .iReady(iReady)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [cRamWidth-1:0] data;
    logic [AW-1:0]        addr;
    logic                 last;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ram model: mem[a] = a + 8'h10, fixed read latency, optional one-shot address corruption
  logic [cLat-1:0]      pv = '0;
  logic [cLat-1:0]      pbad = '0;
  logic [AW-1:0]        pa [cLat];
  logic [cRamWidth-1:0] pd [cLat];
  int                   n_req = 0;
  int                   corrupt_at = 0;

  always @(posedge iClk) begin
    for (int i = cLat - 1; i > 0; i--) begin
      pv[i]   <= pv[i-1];
      pbad[i] <= pbad[i-1];
      pa[i]   <= pa[i-1];
      pd[i]   <= pd[i-1];
    end
    pv[0]   <= oRam.en;
    pd[0]   <= 8'(oRam.addr) + 8'h10;
    pa[0]   <= oRam.addr;
    pbad[0] <= 1'b0;
    if (oRam.en) begin
      n_req <= n_req + 1;
      if (n_req + 1 == corrupt_at) begin
        pa[0]   <= oRam.addr ^ AW'(1);
        pbad[0] <= 1'b1;
      end
    end
  end

  always_comb begin
    iRam.data = pd[cLat-1];
    iRam.addr = pa[cLat-1];
    iRam.dv   = pv[cLat-1];
  end

  // ready driver
  logic       ready_toggle = 1'b0;
  logic       ready_level  = 1'b1;
  logic [3:0] ready_pat    = 4'b1001;
  int         pat_idx      = 0;

  always @(posedge iClk) begin
    #1;
    if (ready_toggle) begin
      iReady = ready_pat[pat_idx % 4];
      pat_idx++;
    end else begin
      iReady = ready_level;
    end
  end

  // stream monitor / scoreboard
  int    cyc = 0;
  int    n_pop = 0;
  int    beats = 0;
  int    first_beat = -1;
  int    last_beat_cyc = -1;
  logic  hold = 1'b0;
  beat_t held;
  beat_t mon_e;

  always @(posedge iClk) cyc <= cyc + 1;

  always @(negedge iClk) begin
    if (iRst) begin
      hold = 1'b0;
    end else begin
      if (hold) check("stall_stable", {oValid, oData, oAddr, oLast}, {1'b1, held});
      hold = oValid && !iReady;
      held = '{data: oData, addr: oAddr, last: oLast};
      if (oValid && iReady) begin
        n_pop++;
        beats++;
        if (first_beat < 0) first_beat = cyc;
        last_beat_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {oData, oAddr}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", oData, mon_e.data);
          check("beat_addr", oAddr, mon_e.addr);
          check("beat_last", oLast, mon_e.last);
        end
      end
    end
  end

  // in-flight plus buffered words must never exceed the FIFO depth
  int   req0 = 0, pop0 = 0, max_occ = 0;
  logic track = 1'b0;

  always @(negedge iClk) begin
    if (track && ((n_req - req0) - (n_pop - pop0)) > max_occ)
      max_occ = (n_req - req0) - (n_pop - pop0);
  end

  task automatic expect_burst(input int base, input int len);
    for (int i = 0; i < len; i++) begin
      int    a;
      beat_t b;
      a      = (base + i) % cRamDepth;
      b.data = 8'(a + 16);
      b.addr = AW'(a);
      b.last = (i == len - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic start(input int base, input int len);
    @(posedge iClk); #1;
    iStart    = 1'b1;
    iBaseAddr = AW'(base);
    iLen      = (AW+1)'(len);
    @(posedge iClk); #1;
    iStart    = 1'b0;
  endtask

  int done_cyc = -1;

  task automatic wait_done(input string name, input int budget);
    int n;
    n        = 0;
    done_cyc = -1;
    while (n < budget) begin
      @(negedge iClk);
      if (oDone) begin
        done_cyc = cyc;
        break;
      end
      n++;
    end
    if (done_cyc < 0) check({name, "_done_timeout"}, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t tmp;
    logic  found;

    // reset state
    repeat (2) @(posedge iClk);
    #1;
    check("rst_busy",  oBusy,  0);
    check("rst_done",  oDone,  0);
    check("rst_err",   oErr,   0);
    check("rst_valid", oValid, 0);
    check("rst_last",  oLast,  0);
    check("rst_oram",  oRam,   0);
    iRst = 1'b0;

    // 1: base 4, len 6, full throughput
    beats = 0; first_beat = -1;
    expect_burst(4, 6);
    start(4, 6);
    @(negedge iClk);
    check("t1_busy", oBusy, 1);
    wait_done("t1", 100);
    check("t1_beats", beats, 6);
    check("t1_back_to_back", last_beat_cyc - first_beat, 5);
    check("t1_done_after_last", done_cyc - last_beat_cyc, 1);
    check("t1_busy_at_done", oBusy, 0);
    check("t1_err", oErr, 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // 2: same burst with ready pattern 1,0,0,1
    beats = 0; req0 = n_req; pop0 = n_pop; max_occ = 0; track = 1'b1;
    pat_idx = 0; ready_toggle = 1'b1;
    expect_burst(4, 6);
    start(4, 6);
    wait_done("t2", 200);
    track = 1'b0; ready_toggle = 1'b0;
    check("t2_beats", beats, 6);
    check("t2_credit_bound", max_occ <= cDepth, 1);
    check("t2_err", oErr, 0);
    check("t2_queue_empty", exp_q.size(), 0);

    // 3: address wrap
    beats = 0;
    expect_burst(cRamDepth - 2, 4);
    start(cRamDepth - 2, 4);
    wait_done("t3", 100);
    check("t3_beats", beats, 4);
    check("t3_err", oErr, 0);

    // 4a: zero-length burst
    beats = 0;
    start(0, 0);
    @(negedge iClk);
    check("t4_zero_done", oDone, 1);
    check("t4_zero_busy", oBusy, 0);
    check("t4_zero_valid", oValid, 0);
    check("t4_zero_en", oRam.en, 0);
    @(negedge iClk);
    check("t4_zero_done_pulse", oDone, 0);
    check("t4_zero_busy2", oBusy, 0);
    check("t4_zero_en2", oRam.en, 0);

    // 4b: iStart during an active burst is ignored
    expect_burst(0, 8);
    start(0, 8);
    repeat (2) @(posedge iClk);
    start(20, 3);
    wait_done("t4", 200);
    check("t4_beats", beats, 8);
    check("t4_queue_empty", exp_q.size(), 0);
    repeat (3) @(negedge iClk);
    check("t4_idle_busy", oBusy, 0);
    check("t4_idle_valid", oValid, 0);

    // 5: reset mid-burst, stale responses dropped
    ready_level = 1'b0;
    beats = 0;
    start(0, 16);
    @(posedge iClk);
    #3 iRst = 1'b1;
    #1;
    check("t5_rst_busy", oBusy, 0);
    check("t5_rst_valid", oValid, 0);
    check("t5_rst_oram", oRam, 0);
    check("t5_rst_done", oDone, 0);
    check("t5_rst_err", oErr, 0);
    exp_q.delete();
    @(posedge iClk); #1;
    iRst = 1'b0;
    repeat (6) @(negedge iClk);
    check("t5_stale_valid", oValid, 0);
    check("t5_stale_err", oErr, 0);
    check("t5_stale_busy", oBusy, 0);
    check("t5_stale_beats", beats, 0);
    ready_level = 1'b1;
    expect_burst(0, 3);
    start(0, 3);
    wait_done("t5", 100);
    check("t5_beats", beats, 3);
    check("t5_err", oErr, 0);

    // 6: corrupted response address on the 3rd read
    beats = 0;
    corrupt_at = n_req + 3;
    expect_burst(10, 5);
    tmp = exp_q[2];
    tmp.addr = AW'(13);
    exp_q[2] = tmp;
    start(10, 5);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iClk);
      if (iRam.dv && pbad[cLat-1]) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_bad_dv_seen", found, 1);
    check("t6_err_before", oErr, 0);
    @(negedge iClk);
    check("t6_err_rises", oErr, 1);
    wait_done("t6", 100);
    check("t6_err_sticky", oErr, 1);
    check("t6_beats", beats, 5);
    corrupt_at = 0;
    beats = 0;
    expect_burst(0, 2);
    start(0, 2);
    @(negedge iClk);
    check("t6_err_cleared", oErr, 0);
    wait_done("t6b", 100);
    check("t6b_beats", beats, 2);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
